// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter sharing one RAM between the CPU (port 0) and the loader (port 1).
// Each access takes one GRANT cycle on the RAM bus followed by one ACK cycle to the winner.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  lock1,
    output logic [1:0]            gnt,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACK
    } state_t;

    state_t                  state_q, state_d;
    logic                    win_q, win_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
    logic                    rr_last_q, rr_last_d;
    logic                    locked_q, locked_d;

    logic                    start;
    logic                    pick;
    logic                    lock_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rr_last_q <= 1'b1;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rr_last_q <= rr_last_d;
            locked_q  <= locked_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        rr_last_d   = rr_last_q;
        locked_d    = locked_q;
        start       = 1'b0;
        pick        = 1'b0;
        lock_active = locked_q & lock1;

        case (state_q)
            IDLE, ACK: begin
                if (!lock1) begin
                    locked_d = 1'b0;
                end
                // A held lock shuts port 0 out entirely, whatever the priority mode.
                if (lock_active) begin
                    if (req1) begin
                        start = 1'b1;
                        pick  = 1'b1;
                    end
                end else if (req0 && req1) begin
                    start = 1'b1;
                    pick  = (FIXED_PRIO != 0) ? 1'b0 : ~rr_last_q;
                end else if (req0 || req1) begin
                    start = 1'b1;
                    pick  = req1;
                end
                state_d = start ? GRANT : IDLE;
            end
            GRANT: begin
                if (!we_q) begin
                    if (win_q) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                end
                state_d = ACK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            win_d     = pick;
            rr_last_d = pick;
            we_d      = pick ? we1 : we0;
            addr_d    = pick ? addr1 : addr0;
            wdata_d   = pick ? wdata1 : wdata0;
            if (pick && lock1) begin
                locked_d = 1'b1;
            end
        end
    end

    assign gnt       = (state_q == GRANT) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign ram_we    = (state_q == GRANT) && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ack0      = (state_q == ACK) && !win_q;
    assign ack1      = (state_q == ACK) && win_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule
